// File: rtl/ddr_port_arbiter.sv
// Shares one DDR controller port between NUM_PORTS requesters, one transaction in flight at a time.
// Latency: accept -> mem strobe +2 cycles; mem_ready -> resp_valid +1 cycle (min 4 cycles/txn).
// Backpressure: req_ready only in IDLE; requesters hold req_valid until accepted, nothing is buffered.
module ddr_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic                          resp_err,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_re,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic                          busy,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id
);

    localparam int GW = $clog2(NUM_PORTS);
    // Last WAIT count value before the error completion fires.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t               state_q, state_d;
    req_t                 cur_q, win_req;
    logic [GW-1:0]        last_q, grant_q, win_idx;
    logic                 win_found;
    logic [15:0]          tmo_cnt_q;
    logic                 done_ok, done_tmo;
    logic [NUM_PORTS-1:0] grant_onehot;
    int                   cand;

    // Winner selection: rotate from the port after the last winner, or lowest index in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (FIXED_PRIO != 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(i);
                end
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid port is assigned last.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                cand = int'(last_q) + k;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
                if (req_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(cand);
                end
            end
        end
    end

    // Pick the winning port's request fields out of the packed input buses.
    always_comb begin
        win_req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (GW'(p) == win_idx) begin
                win_req.we    = req_we[p];
                win_req.addr  = req_addr[p*ADDR_W +: ADDR_W];
                win_req.wdata = req_wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // A WAIT cycle ends either on controller completion or on the final unanswered count.
    assign done_ok  = (state_q == S_WAIT) && mem_ready;
    assign done_tmo = (state_q == S_WAIT) && !mem_ready && (tmo_cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed setup/issue sequence, WAIT exits on completion or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_SETUP;
            S_SETUP: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_ok || done_tmo) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE, single-cycle strobe only in ISSUE.
    always_comb begin
        req_ready = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                mem_re = ~cur_q.we;
                mem_we = cur_q.we;
            end
            default: ;
        endcase
    end

    // Latch the accepted request; it drives the controller unchanged until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(NUM_PORTS - 1);
        end else if (state_q == S_IDLE && win_found) begin
            cur_q   <= win_req;
            grant_q <= win_idx;
            last_q  <= win_idx;
        end
    end

    // Saturating WAIT-cycle counter, restarted on every issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT && tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign grant_onehot = NUM_PORTS'(1) << grant_q;

    // Response pulse to the winner; read data held until the next completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            if (done_ok) begin
                resp_valid <= grant_onehot;
                resp_rdata <= cur_q.we ? '0 : mem_rdata;
            end else if (done_tmo) begin
                resp_valid <= grant_onehot;
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end
        end
    end

    assign mem_addr  = cur_q.addr;
    assign mem_wdata = cur_q.wdata;
    assign grant_id  = grant_q;

endmodule
